i2c_slave_regs: RTL and testbench



---
 rtl/i2c_pkg.sv | 17 +
 rtl/i2c_line_filter.sv | 44 ++++
 rtl/i2c_slave_regs.sv | 184 ++++++++++++++++++
 tb/tb_i2c_slave_regs.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register-access target.
package i2c_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam logic ACK = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_SUB,
    ST_WDATA,
    ST_RDATA,
    ST_ACK
  } state_t;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer followed by a FILT_LEN-sample glitch filter.
// Emits the filtered level plus single-cycle rise/fall pulses.
module i2c_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(FILT_LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Idle bus level is high, so the filter comes out of reset at 1.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sync  <= 2'b11;
      cnt   <= '0;
      level <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], din};
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT_LEN - 1)) begin
        cnt   <= '0;
        level <= sync[1];
        rise  <= sync[1];
        fall  <= ~sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target that turns address/sub-address/data traffic into a
// single-cycle register access port toward a host register bank.
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h39,
  parameter int         FILT_LEN   = 3
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              I2C_SCLK,
  inout  wire               I2C_SDAT,
  output logic [ADDR_W-1:0] REG_ADDR,
  output logic [DATA_W-1:0] REG_WDATA,
  output logic              REG_WE,
  input  logic [DATA_W-1:0] REG_RDATA,
  output logic              BUSY
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det;

  state_t      state;
  state_t      ack_next;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift;
  logic [7:0]  byte_in;
  logic        sda_oe;
  logic        rd_load;
  logic        we_pend;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .iCLK  (iCLK),
    .iRST_N(iRST_N),
    .din   (I2C_SCLK),
    .level (scl_lvl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .iCLK  (iCLK),
    .iRST_N(iRST_N),
    .din   (I2C_SDAT),
    .level (sda_lvl),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;
  assign byte_in   = {shift[6:0], sda_lvl};

  // Open drain: only ever pull low.
  assign I2C_SDAT = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= ST_IDLE;
      ack_next  <= ST_IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      sda_oe    <= 1'b0;
      rd_load   <= 1'b0;
      we_pend   <= 1'b0;
      REG_ADDR  <= '0;
      REG_WDATA <= '0;
      REG_WE    <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      we_pend <= 1'b0;
      REG_WE  <= we_pend;
      // Pointer advances only after the strobe so the write sees the old address.
      if (REG_WE) begin
        REG_ADDR <= REG_ADDR + 8'd1;
      end

      if (stop_det) begin
        state   <= ST_IDLE;
        sda_oe  <= 1'b0;
        BUSY    <= 1'b0;
        bit_cnt <= '0;
        rd_load <= 1'b0;
      end else if (start_det) begin
        state   <= ST_ADDR;
        sda_oe  <= 1'b0;
        bit_cnt <= '0;
        rd_load <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: begin
            if (scl_rise) begin
              shift   <= byte_in;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                if (byte_in[7:1] != SLAVE_ADDR) begin
                  state <= ST_IDLE;
                  BUSY  <= 1'b0;
                end else begin
                  state    <= ST_ACK;
                  BUSY     <= 1'b1;
                  ack_next <= byte_in[0] ? ST_RDATA : ST_SUB;
                end
              end
            end
          end

          ST_SUB: begin
            if (scl_rise) begin
              shift   <= byte_in;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                REG_ADDR <= byte_in;
                state    <= ST_ACK;
                ack_next <= ST_WDATA;
              end
            end
          end

          ST_WDATA: begin
            if (scl_rise) begin
              shift   <= byte_in;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                REG_WDATA <= byte_in;
                we_pend   <= 1'b1;
                state     <= ST_ACK;
                ack_next  <= ST_WDATA;
              end
            end
          end

          // First fall after bit 7 asserts ACK, the following fall ends it.
          ST_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                state   <= ack_next;
                if (ack_next == ST_RDATA) begin
                  shift  <= {REG_RDATA[6:0], 1'b0};
                  sda_oe <= ~REG_RDATA[7];
                end
              end
            end
          end

          ST_RDATA: begin
            if (scl_fall) begin
              if (rd_load) begin
                rd_load <= 1'b0;
                shift   <= {REG_RDATA[6:0], 1'b0};
                sda_oe  <= ~REG_RDATA[7];
              end else if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b0;
              end else if (bit_cnt != 4'd0) begin
                sda_oe <= ~shift[7];
                shift  <= {shift[6:0], 1'b0};
              end
            end else if (scl_rise) begin
              if (bit_cnt == 4'd8) begin
                REG_ADDR <= REG_ADDR + 8'd1;
                bit_cnt  <= '0;
                if (sda_lvl == ACK) begin
                  rd_load <= 1'b1;
                end else begin
                  state <= ST_IDLE;
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench: a bit-banged I2C master against i2c_slave_regs with a small host memory.
module tb_i2c_slave_regs;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl = 1'b1;
  logic sda_drv_low = 1'b0;
  wire  sda_bus;

  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, busy;

  logic [7:0] host_mem [256];
  logic [7:0] we_addr_log [32];
  logic [7:0] we_data_log [32];
  int we_cnt = 0;
  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  assign sda_bus = sda_drv_low ? 1'b0 : 1'bz;
  pullup (sda_bus);
  assign reg_rdata = host_mem[reg_addr];

  i2c_slave_regs #(.SLAVE_ADDR(7'h39), .FILT_LEN(3)) dut (
    .iCLK     (clk),
    .iRST_N   (rst_n),
    .I2C_SCLK (scl),
    .I2C_SDAT (sda_bus),
    .REG_ADDR (reg_addr),
    .REG_WDATA(reg_wdata),
    .REG_WE   (reg_we),
    .REG_RDATA(reg_rdata),
    .BUSY     (busy)
  );

  always @(posedge clk) begin
    if (reg_we) begin
      if (we_cnt < 32) begin
        we_addr_log[we_cnt] <= reg_addr;
        we_data_log[we_cnt] <= reg_wdata;
      end
      we_cnt <= we_cnt + 1;
      $display("REG_WE addr=0x%02h data=0x%02h", reg_addr, reg_wdata);
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic qtr();
    repeat (32) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_drv_low = 1'b0; qtr();
    scl = 1'b1; qtr();
    sda_drv_low = 1'b1; qtr();
    scl = 1'b0; qtr();
    $display("bus START");
  endtask

  task automatic bus_stop();
    scl = 1'b0; sda_drv_low = 1'b1; qtr();
    scl = 1'b1; qtr();
    sda_drv_low = 1'b0; qtr();
    $display("bus STOP");
  endtask

  // glitch: 0 none, 1 one-cycle SCL low pulse, 2 one-cycle SDA inversion (both while SCL high)
  task automatic send_bit(input logic b, input int glitch);
    sda_drv_low = ~b; qtr();
    scl = 1'b1; qtr();
    if (glitch == 1) begin
      scl = 1'b0; @(negedge clk); scl = 1'b1;
    end
    if (glitch == 2) begin
      sda_drv_low = ~sda_drv_low; @(negedge clk); sda_drv_low = ~sda_drv_low;
    end
    qtr();
    scl = 1'b0; qtr();
  endtask

  task automatic write_byte(input logic [7:0] d, input int gsc, input int gsd, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      send_bit(d[i], ((7 - i) == gsc) ? 1 : (((7 - i) == gsd) ? 2 : 0));
    end
    sda_drv_low = 1'b0; qtr();
    scl = 1'b1; qtr();
    ack = sda_bus; qtr();
    scl = 1'b0; qtr();
    $display("wr byte 0x%02h ack_bit=%0b", d, ack);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d);
    sda_drv_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      qtr(); scl = 1'b1;
      qtr(); d[i] = sda_bus;
      qtr(); scl = 1'b0;
      qtr();
    end
    sda_drv_low = master_ack; qtr();
    scl = 1'b1; qtr(); qtr();
    scl = 1'b0; qtr();
    sda_drv_low = 1'b0;
    $display("rd byte 0x%02h master_ack=%0b", d, master_ack);
  endtask

  initial begin
    logic       ab;
    logic [7:0] rd;
    int         base;

    for (int i = 0; i < 256; i++) host_mem[i] = 8'(i) ^ 8'h5A;
    host_mem[8'h41] = 8'h10;
    host_mem[8'h42] = 8'h20;

    repeat (5) @(negedge clk);
    chk("rst_addr", reg_addr, 8'h00);
    chk("rst_wdata", reg_wdata, 8'h00);
    chk("rst_we", reg_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sda", sda_bus, 1);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Single write
    base = we_cnt;
    bus_start();
    write_byte(8'h72, -1, -1, ab); chk("t1_ack_dev", ab, 0);
    chk("t1_busy", busy, 1);
    write_byte(8'h15, -1, -1, ab); chk("t1_ack_sub", ab, 0);
    write_byte(8'h20, -1, -1, ab); chk("t1_ack_dat", ab, 0);
    bus_stop();
    chk("t1_we_cnt", we_cnt - base, 1);
    chk("t1_we_addr", we_addr_log[base], 8'h15);
    chk("t1_we_data", we_data_log[base], 8'h20);
    chk("t1_ptr", reg_addr, 8'h16);
    chk("t1_busy_end", busy, 0);

    // Burst write wrapping through 0xFF
    base = we_cnt;
    bus_start();
    write_byte(8'h72, -1, -1, ab); chk("t2_ack_dev", ab, 0);
    write_byte(8'hFE, -1, -1, ab); chk("t2_ack_sub", ab, 0);
    write_byte(8'hA1, -1, -1, ab); chk("t2_ack_d0", ab, 0);
    write_byte(8'hB2, -1, -1, ab); chk("t2_ack_d1", ab, 0);
    write_byte(8'hC3, -1, -1, ab); chk("t2_ack_d2", ab, 0);
    bus_stop();
    chk("t2_we_cnt", we_cnt - base, 3);
    chk("t2_a0", we_addr_log[base], 8'hFE);
    chk("t2_d0", we_data_log[base], 8'hA1);
    chk("t2_a1", we_addr_log[base + 1], 8'hFF);
    chk("t2_d1", we_data_log[base + 1], 8'hB2);
    chk("t2_a2", we_addr_log[base + 2], 8'h00);
    chk("t2_d2", we_data_log[base + 2], 8'hC3);
    chk("t2_ptr", reg_addr, 8'h01);

    // Combined read with repeated start
    base = we_cnt;
    bus_start();
    write_byte(8'h72, -1, -1, ab); chk("t3_ack_dev", ab, 0);
    write_byte(8'h41, -1, -1, ab); chk("t3_ack_sub", ab, 0);
    bus_start();
    write_byte(8'h73, -1, -1, ab); chk("t3_ack_rd", ab, 0);
    read_byte(1'b1, rd); chk("t3_rd0", rd, 8'h10);
    read_byte(1'b0, rd); chk("t3_rd1", rd, 8'h20);
    chk("t3_sda_rel", sda_bus, 1);
    chk("t3_ptr", reg_addr, 8'h43);
    read_byte(1'b0, rd); chk("t3_idle_bus", rd, 8'hFF);
    chk("t3_ptr_idle", reg_addr, 8'h43);
    bus_stop();
    chk("t3_busy_end", busy, 0);
    chk("t3_no_we", we_cnt - base, 0);

    // Wrong address
    base = we_cnt;
    bus_start();
    write_byte(8'h74, -1, -1, ab); chk("t4_nack", ab, 1);
    chk("t4_busy", busy, 0);
    write_byte(8'h00, -1, -1, ab); chk("t4_nack2", ab, 1);
    bus_stop();
    chk("t4_no_we", we_cnt - base, 0);

    // Abort mid data byte, then a clean write
    base = we_cnt;
    bus_start();
    write_byte(8'h72, -1, -1, ab); chk("t5_ack_dev", ab, 0);
    write_byte(8'h30, -1, -1, ab); chk("t5_ack_sub", ab, 0);
    send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
    bus_stop();
    chk("t5_no_we", we_cnt - base, 0);
    chk("t5_ptr", reg_addr, 8'h30);
    chk("t5_busy", busy, 0);
    bus_start();
    write_byte(8'h72, -1, -1, ab); chk("t5b_ack_dev", ab, 0);
    write_byte(8'h80, -1, -1, ab); chk("t5b_ack_sub", ab, 0);
    write_byte(8'h99, -1, -1, ab); chk("t5b_ack_dat", ab, 0);
    bus_stop();
    chk("t5b_we_cnt", we_cnt - base, 1);
    chk("t5b_we_addr", we_addr_log[base], 8'h80);
    chk("t5b_we_data", we_data_log[base], 8'h99);
    chk("t5b_ptr", reg_addr, 8'h81);

    // Glitches on SCL (bit 1) and SDA (bit 3) of the data byte
    base = we_cnt;
    bus_start();
    write_byte(8'h72, -1, -1, ab); chk("t6_ack_dev", ab, 0);
    write_byte(8'h05, -1, -1, ab); chk("t6_ack_sub", ab, 0);
    write_byte(8'h3C, 1, 3, ab); chk("t6_ack_dat", ab, 0);
    bus_stop();
    chk("t6_we_cnt", we_cnt - base, 1);
    chk("t6_we_addr", we_addr_log[base], 8'h05);
    chk("t6_we_data", we_data_log[base], 8'h3C);

    // Reset asserted while the target is holding ACK
    bus_start();
    for (int i = 7; i >= 0; i--) begin
      rd = 8'h72;
      send_bit(rd[i], 0);
    end
    sda_drv_low = 1'b0; qtr();
    chk("t7_ack_held", sda_bus, 0);
    #3 rst_n = 1'b0;
    #1 chk("t7_rst_release", sda_bus, 1);
    chk("t7_rst_busy", busy, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    qtr();
    bus_stop();
    base = we_cnt;
    bus_start();
    write_byte(8'h72, -1, -1, ab); chk("t7_ack_dev", ab, 0);
    write_byte(8'h10, -1, -1, ab); chk("t7_ack_sub", ab, 0);
    write_byte(8'h55, -1, -1, ab); chk("t7_ack_dat", ab, 0);
    bus_stop();
    chk("t7_we_cnt", we_cnt - base, 1);
    chk("t7_we_data", we_data_log[base], 8'h55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
